// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: config register map and FSM states.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    CFG_ACK    = 2'd0,
    CFG_ENABLE = 2'd1,
    CFG_VECTOR = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_addr_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } intr_state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set request bit.
module intr_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downward so the lowest set index is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (req_i[i-1]) idx_o = IW'(i - 1);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Single-level, non-nesting interrupt controller: pending register, config registers,
// and a two-state IDLE/HANDLER FSM that redirects the CPU on instruction retire.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int XLEN = 32,
  localparam int CW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_evt,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [XLEN-1:0] cfg_wdata,
  input  logic            retire,
  input  logic [XLEN-1:0] next_pc,
  input  logic            iret,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] ret_pc,
  output logic [NSRC-1:0] irr,
  output logic [CW-1:0]   cause,
  output logic            in_service
);

  intr_state_e     state_q, state_d;
  logic [NSRC-1:0] irr_q, irr_d;
  logic            enable_q, enable_d;
  logic [XLEN-1:0] vector_q, vector_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [CW-1:0]   cause_q, cause_d;
  logic [NSRC-1:0] ack_mask;
  logic [CW-1:0]   prio_idx;
  logic            prio_valid;
  logic            take_trap;

  intr_prio_enc #(.N(NSRC), .IW(CW)) u_prio (
    .req_i   (irr_q),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  // Only the registered pending bits are considered; this-cycle events wait a cycle.
  assign take_trap = (state_q == ST_IDLE) && retire && enable_q && prio_valid;

  always_comb begin
    ack_mask = '0;
    if (cfg_we && (cfg_addr == CFG_ACK)) ack_mask = cfg_wdata[NSRC-1:0];
  end

  // A new event overrides a same-cycle acknowledge of the same bit.
  assign irr_d    = (irr_q & ~ack_mask) | src_evt;
  assign enable_d = (cfg_we && (cfg_addr == CFG_ENABLE)) ? cfg_wdata[0] : enable_q;
  assign vector_d = (cfg_we && (cfg_addr == CFG_VECTOR)) ? cfg_wdata : vector_q;
  assign epc_d    = take_trap ? next_pc  : epc_q;
  assign cause_d  = take_trap ? prio_idx : cause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irr_q    <= '0;
      enable_q <= 1'b0;
      vector_q <= '0;
      epc_q    <= '0;
      cause_q  <= '0;
    end else begin
      irr_q    <= irr_d;
      enable_q <= enable_d;
      vector_q <= vector_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (take_trap) state_d = ST_HANDLER;
      ST_HANDLER: if (iret)      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trap       = 1'b0;
    in_service = 1'b0;
    unique case (state_q)
      ST_IDLE:    trap       = take_trap;
      ST_HANDLER: in_service = 1'b1;
      default:    ;
    endcase
  end

  assign trap_pc = vector_q;
  assign ret_pc  = epc_q;
  assign irr     = irr_q;
  assign cause   = cause_q;

endmodule
